// File: rtl/psum_out_fifo_if.sv
// Handshake bundle between the convolution datapath, the psum output FIFO and its consumer.
// The write side, read side, clear and status flags travel together.
interface psum_out_fifo_if #(
   parameter int unsigned DATA_WIDTH = 17,
   parameter int unsigned ADDR_LEN   = 3
);
   logic                  clr;
   logic                  wen;
   logic [DATA_WIDTH-1:0] din;
   logic                  full;
   logic                  ren;
   logic [DATA_WIDTH-1:0] dout;
   logic                  empty;
   logic [ADDR_LEN:0]     count;
   logic                  overflow;
   logic                  underflow;

   modport slave (
      input  clr, wen, din, ren,
      output full, dout, empty, count, overflow, underflow
   );

   modport master (
      output clr, wen, din, ren,
      input  full, dout, empty, count, overflow, underflow
   );
endinterface

// File: rtl/psum_out_fifo.sv
// Power-of-two circular FIFO buffering finished partial sums from the convolution datapath.
// Reads are first-word-fall-through; full/empty come from registered state so backpressure is glitch-free.
module psum_out_fifo #(
   parameter int unsigned DATA_WIDTH = 17,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_LEN   = 3
) (
   input logic              clk,
   input logic              rst,
   psum_out_fifo_if.slave   bus
);
   localparam int unsigned CNT_W = ADDR_LEN + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_LEN-1:0]   wptr;
   logic [ADDR_LEN-1:0]   rptr;
   logic [CNT_W-1:0]      cnt;
   logic                  full_q;
   logic                  empty_q;
   logic                  overflow_q;
   logic                  underflow_q;

   logic                  wr_ok_c;
   logic                  rd_ok_c;
   logic [CNT_W-1:0]      cnt_nxt_c;

   // Acceptance uses the flags as they stand before this edge: a full FIFO drops the write even if it pops.
   always_comb begin
      wr_ok_c   = 1'b0;
      rd_ok_c   = 1'b0;
      cnt_nxt_c = cnt;
      if (!bus.clr) begin
         wr_ok_c   = bus.wen & ~full_q;
         rd_ok_c   = bus.ren & ~empty_q;
         cnt_nxt_c = cnt + CNT_W'(wr_ok_c) - CNT_W'(rd_ok_c);
      end
   end

   // Storage is zeroed by reset only; clr leaves contents in place.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem <= '{default: '0};
      end else if (wr_ok_c) begin
         mem[wptr] <= bus.din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr        <= '0;
         rptr        <= '0;
         cnt         <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.clr) begin
         wptr        <= '0;
         rptr        <= '0;
         cnt         <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_ok_c) wptr <= wptr + ADDR_LEN'(1);
         if (rd_ok_c) rptr <= rptr + ADDR_LEN'(1);
         cnt         <= cnt_nxt_c;
         full_q      <= (cnt_nxt_c == CNT_W'(DEPTH));
         empty_q     <= (cnt_nxt_c == '0);
         overflow_q  <= overflow_q  | (bus.wen & full_q);
         underflow_q <= underflow_q | (bus.ren & empty_q);
      end
   end

   assign bus.dout      = mem[rptr];
   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.count     = cnt;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_psum_out_fifo.sv
// Bench for psum_out_fifo: directed vector table, corner-case sequences and a queue-model random run.
module tb_psum_out_fifo;
   localparam int unsigned DW    = 17;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AL    = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   psum_out_fifo_if #(.DATA_WIDTH(DW), .ADDR_LEN(AL)) bus ();

   psum_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_LEN(AL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic          clr, wen, ren;
      logic [DW-1:0] din;
      int            cnt;
      logic          emp, ful, ovf, unf, dchk;
      logic [DW-1:0] dout;
   } vec_t;

   vec_t vecs [64];
   int   nv = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_state(input string tag, input int cnt, input logic emp, input logic ful,
                            input logic ovf, input logic unf);
      chk({tag, ".count"},     32'(bus.count),     32'(cnt));
      chk({tag, ".empty"},     32'(bus.empty),     32'(emp));
      chk({tag, ".full"},      32'(bus.full),      32'(ful));
      chk({tag, ".overflow"},  32'(bus.overflow),  32'(ovf));
      chk({tag, ".underflow"}, 32'(bus.underflow), 32'(unf));
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
   task automatic step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
      bus.clr = c; bus.wen = w; bus.ren = r; bus.din = d;
      @(posedge clk);
      #1;
      bus.clr = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0;
   endtask

   task automatic add(input logic c, input logic w, input logic r, input logic [DW-1:0] d,
                      input int cnt, input logic emp, input logic ful, input logic ovf,
                      input logic unf, input logic dchk, input logic [DW-1:0] dout);
      vecs[nv] = '{clr: c, wen: w, ren: r, din: d, cnt: cnt, emp: emp, ful: ful,
                   ovf: ovf, unf: unf, dchk: dchk, dout: dout};
      nv++;
   endtask

   task automatic fill(input int n, input int base);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, DW'(base + k));
   endtask

   int unsigned q[$];
   logic        m_ovf, m_unf;

   initial begin
      bus.clr = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0; bus.din = '0;

      // Reset then idle
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      chk_state("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("reset.dout", 32'(bus.dout), 32'h0);

      // Directed table: fill, overflow, drain, underflow, clears, empty corner
      for (int k = 1; k <= 8; k++)
         add(1'b0, 1'b1, 1'b0, DW'(k), k, 1'b0, (k == 8), 1'b0, 1'b0, 1'b1, DW'(1));
      add(1'b0, 1'b1, 1'b0, DW'('h1FFFF), 8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, DW'(1));
      for (int k = 1; k <= 8; k++)
         add(1'b0, 1'b0, 1'b1, '0, 8 - k, (k == 8), 1'b0, 1'b1, 1'b0, (k < 8), DW'(k + 1));
      add(1'b0, 1'b0, 1'b1, '0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      add(1'b1, 1'b0, 1'b0, '0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      add(1'b0, 1'b1, 1'b1, DW'('h0ABCD), 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, DW'('h0ABCD));
      add(1'b1, 1'b1, 1'b0, DW'(5), 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < nv; i++) begin
         step(vecs[i].clr, vecs[i].wen, vecs[i].ren, vecs[i].din);
         chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].emp, vecs[i].ful,
                   vecs[i].ovf, vecs[i].unf);
         if (vecs[i].dchk) chk($sformatf("vec%0d.dout", i), 32'(bus.dout), 32'(vecs[i].dout));
      end

      // Full with simultaneous read and write: pop wins, write dropped
      step(1'b1, 1'b0, 1'b0, '0);
      fill(8, 1);
      step(1'b0, 1'b1, 1'b1, DW'('h1234));
      chk_state("fullrw", 7, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("fullrw.drain%0d", k), 32'(bus.dout), 32'(k + 2));
         step(1'b0, 1'b0, 1'b1, '0);
      end
      chk("fullrw.empty", 32'(bus.empty), 32'h1);

      // Steady read+write at count 3 across pointer wrap
      step(1'b1, 1'b0, 1'b0, '0);
      fill(3, 100);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 1'b1, DW'(103 + i));
         chk($sformatf("stream%0d.count", i), 32'(bus.count), 32'd3);
         chk($sformatf("stream%0d.dout", i), 32'(bus.dout), 32'(101 + i));
      end

      // clr with wen on a partly full FIFO
      step(1'b1, 1'b0, 1'b0, '0);
      fill(5, 'h40);
      step(1'b1, 1'b1, 1'b0, DW'('h55));
      chk_state("clrw", 0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0);
      chk("clrw.hold", 32'(bus.count), 32'd0);

      // Asynchronous reset mid-cycle, then write on the first edge after release
      fill(5, 'h60);
      #2 rst = 1'b0;
      #1;
      chk_state("arst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("arst.dout", 32'(bus.dout), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 1'b1, 1'b0, DW'('h77));
      chk("arst.first_wr.count", 32'(bus.count), 32'd1);
      chk("arst.first_wr.dout", 32'(bus.dout), 32'h77);

      // Randomised traffic against a queue model
      step(1'b1, 1'b0, 1'b0, '0);
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      for (int i = 0; i < 600; i++) begin
         logic          c, w, r, was_full, was_empty;
         logic [DW-1:0] d;
         c = ($urandom_range(0, 49) == 0);
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 45);
         d = DW'($urandom);
         step(c, w, r, d);
         if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (r && !was_empty) void'(q.pop_front());
            if (w && !was_full) q.push_back(32'(d));
            m_ovf = m_ovf | (w & was_full);
            m_unf = m_unf | (r & was_empty);
         end
         chk_state($sformatf("rnd%0d", i), q.size(), (q.size() == 0), (q.size() == DEPTH),
                   m_ovf, m_unf);
         if (q.size() != 0) chk($sformatf("rnd%0d.dout", i), 32'(bus.dout), q[0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/psum_out_fifo.md
# psum_out_fifo

Output buffer that sits directly downstream of the convolution datapath. It captures each finished partial sum, presented with the write strobe, and returns backpressure through a registered full flag, which the datapath uses to stall its pipeline. Storage is a power-of-two circular FIFO. Downstream logic drains it through a first-word-fall-through read port.

## Interface
- DATA_WIDTH, 17, psum width; equals IF_SCRATCH_WIDTH + FILT_SCRATCH_WIDTH + 1 (8 + 8 + 1).
- DEPTH, 8, number of entries; must be a power of two, ≥ 2.
- ADDR_LEN, 3, log2(DEPTH).
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of pointers, count and sticky flags; memory contents are untouched.
- wen  input  1  write strobe; driven by datapath outbuf_write.
- din  input  DATA_WIDTH  psum value; driven by datapath module_outval.
- full  output  1  FIFO holds DEPTH entries; drives datapath outbuf_full.
- ren  input  1  read/pop request from the consumer.
- dout  output  DATA_WIDTH  head entry, valid while empty = 0.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_LEN+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a write is dropped.
- underflow  output  1  sticky; set when a read is attempted while empty.

## Operation
- Storage: DEPTH × DATA_WIDTH register array, wptr and rptr of ADDR_LEN bits, and a count register of ADDR_LEN+1 bits.
- Write acceptance: wr_ok = wen & ~full. On an accepted write, mem[wptr] ← din and wptr ← wptr+1 mod DEPTH.
- Read acceptance: rd_ok = ren & ~empty. On an accepted read, rptr ← rptr+1 mod DEPTH.
- count ← count + wr_ok − rd_ok. A simultaneous accepted read and write leaves count unchanged.
- full = (count == DEPTH) and empty = (count == 0); both are decoded from the count register, so they are glitch-free registered-state outputs.
- Simultaneous wen & ren when full: the read is accepted and the write is dropped (full is evaluated before the pop). overflow is set and count goes to DEPTH−1.
- Simultaneous wen & ren when empty: the write is accepted and the read is ignored. underflow is set and count goes to 1.
- wen while full with ren = 0: the write is dropped, overflow is set, and pointers and memory are unchanged.
- ren while empty with wen = 0: no change except that underflow is set.
- Pointer wrap-around is natural modulo-DEPTH overflow of ADDR_LEN bits; no special case is needed.
- dout = mem[rptr], read combinationally (first-word-fall-through). When empty, dout shows stale contents, which the consumer must ignore.
- clr: pointers, count, overflow and underflow return to 0, and any wen/ren in the same cycle is ignored. clr has priority over all other operations.
- Reset (rst = 0), asynchronous:
  - wptr = rptr = count = 0.
  - Every memory entry = 0, so dout = 0.
  - empty = 1, full = 0, overflow = 0, underflow = 0.
- Reset mid-operation discards all buffered data immediately, without waiting for a clock edge.
- Sticky flags are cleared only by rst or clr.

## Timing
- Write-to-read latency is 1 cycle:
  - A write accepted at edge N is visible on dout, with empty = 0, after edge N.
  - The consumer can pop it at edge N+1.
- full asserts after the edge that stores entry DEPTH. The datapath sees it in the same cycle it would issue the next write, so no write is lost as long as the datapath honours full combinationally.
- full deasserts after the edge of the first accepted pop.
- Sustained throughput: one write and one read per cycle when 0 < count < DEPTH.
- Reset release: the first write is accepted at the first rising edge with rst = 1.

## Test plan
- Reset then idle: hold rst = 0 for 2 cycles, release → empty = 1, full = 0, count = 0, dout = 0, both flags 0.
- Fill and drain: write 0x00001..0x00008 on 8 consecutive cycles → full = 1 after the 8th edge, count = 8. Pop 8 times → dout sequence 0x00001..0x00008, empty = 1 after the last pop.
- Overflow: fill to 8, write 0x1FFFF with ren = 0 → overflow = 1, count = 8, contents unchanged. Then pop all 8 → 0x1FFFF never appears.
- Simultaneous read/write:
  - count = 3, wen = ren = 1 for 20 cycles → count stays 3 and data stays in order across pointer wrap.
  - Full with wen = ren = 1 → count = 7, overflow = 1.
- Empty corner: count = 0, wen = ren = 1, din = 0x0ABCD → count = 1, dout = 0x0ABCD, underflow = 1.
- Async reset and clr:
  - Fill to 5, pull rst low mid-cycle → count = 0 and empty = 1 before the next edge.
  - Separately, fill to 5 and pulse clr with wen = 1 → count = 0, overflow = 0, and the write is ignored.
